// File: rtl/display_update_sequencer.sv
// Frame-synchronous commit of ultrasound location/orientation updates to the VGA writer.
// Optional build macro SEQ_AUTOSCALE_EN adds the SCALE state that picks the largest fitting scale.
module display_update_sequencer #(
    parameter int SCALE_MAX    = 4,
    parameter int GRID_LIMIT   = 256,
    parameter int STALE_FRAMES = 60
) (
    input  logic        vclock,
    input  logic        reset,
    input  logic        vsync,
    input  logic        loc_valid,
    input  logic [11:0] loc_data,
    output logic        loc_ack,
    input  logic        ori_valid,
    input  logic [4:0]  ori_data,
    output logic        ori_ack,
    output logic [11:0] location,
    output logic [4:0]  orientation,
    output logic        new_data,
    output logic        orientation_ready,
    output logic [2:0]  scale_factor,
    output logic        stale
);

    // state  | meaning
    // IDLE   | accepting requests, waiting for a frame start
    // COMMIT | one cycle: move full slots to the outputs
    // SCALE  | search scale factor from SCALE_MAX down to 1

    localparam int CNT_W = $clog2(STALE_FRAMES + 1);
    localparam logic [CNT_W-1:0] STALE_MAX = CNT_W'(STALE_FRAMES);

`ifdef SEQ_AUTOSCALE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, COMMIT = 2'd1, SCALE = 2'd2} state_t;
    localparam logic [2:0]  SCALE_TOP = 3'(SCALE_MAX);
    localparam logic [11:0] GRID_LIM  = 12'(GRID_LIMIT);
`else
    typedef enum logic [1:0] {IDLE = 2'd0, COMMIT = 2'd1} state_t;
`endif

    state_t             state;
    state_t             state_nxt;
    logic               vsync_d;
    logic               frame_start;
    logic               loc_full;
    logic               ori_full;
    logic [11:0]        loc_slot;
    logic [4:0]         ori_slot;
    logic [CNT_W-1:0]   stale_cnt;
    logic               idle_hold;
    logic               loc_take;
    logic               ori_take;
    logic               stale_hit;
    logic               scale_done;

    assign frame_start = vsync_d & ~vsync;

`ifdef SEQ_AUTOSCALE_EN
    logic [2:0]  scale_cnt;
    logic [10:0] scale_prod;
    logic        scale_fits;
    logic [2:0]  scale_reg;

    assign scale_prod = 11'(location[11:4]) * 11'(scale_cnt);
    assign scale_fits = ({1'b0, scale_prod} <= GRID_LIM);
    assign scale_factor = scale_reg;
`else
    assign scale_factor = 3'd2;
`endif

    always_comb begin
        state_nxt  = state;
        scale_done = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start && (loc_full || ori_full)) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
`ifdef SEQ_AUTOSCALE_EN
                state_nxt = loc_full ? SCALE : IDLE;
`else
                state_nxt = IDLE;
`endif
            end
`ifdef SEQ_AUTOSCALE_EN
            SCALE: begin
                scale_done = scale_fits || (scale_cnt == 3'd1);
                if (scale_done) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Acks are only raised when the following cycle is guaranteed to be IDLE,
    // so a capture never collides with a commit emptying the slots.
    assign idle_hold = (state == IDLE) && (state_nxt == IDLE);
    assign loc_take  = loc_valid && !loc_full && !loc_ack && idle_hold;
    assign ori_take  = ori_valid && !ori_full && !ori_ack && idle_hold;

    // A frame start that will lead to a location commit does not age the data.
    assign stale_hit = frame_start && !((state == IDLE) && loc_full);

    always_ff @(posedge vclock) begin
        if (reset) begin
            state             <= IDLE;
            vsync_d           <= 1'b0;
            loc_ack           <= 1'b0;
            ori_ack           <= 1'b0;
            loc_full          <= 1'b0;
            ori_full          <= 1'b0;
            loc_slot          <= '0;
            ori_slot          <= '0;
            location          <= '0;
            orientation       <= '0;
            new_data          <= 1'b0;
            orientation_ready <= 1'b0;
            stale             <= 1'b0;
            stale_cnt         <= '0;
        end else begin
            state    <= state_nxt;
            vsync_d  <= vsync;
            loc_ack  <= loc_take;
            ori_ack  <= ori_take;
            new_data <= 1'b0;

            if (loc_ack) begin
                loc_full <= 1'b1;
                loc_slot <= loc_data;
            end
            if (ori_ack) begin
                ori_full <= 1'b1;
                ori_slot <= ori_data;
            end

            if (stale_hit) begin
                if (stale_cnt != STALE_MAX) begin
                    stale_cnt <= stale_cnt + 1'b1;
                end
                if ((stale_cnt == STALE_MAX) || (stale_cnt == STALE_MAX - 1'b1)) begin
                    stale             <= 1'b1;
                    orientation_ready <= 1'b0;
                end
            end

            // Commit has priority over the stale update in the same cycle.
            if (state == COMMIT) begin
                if (loc_full) begin
                    location  <= loc_slot;
                    new_data  <= 1'b1;
                    stale_cnt <= '0;
                    stale     <= 1'b0;
                end
                if (ori_full) begin
                    orientation       <= ori_slot;
                    orientation_ready <= 1'b1;
                end
                loc_full <= 1'b0;
                ori_full <= 1'b0;
            end
        end
    end

`ifdef SEQ_AUTOSCALE_EN
    always_ff @(posedge vclock) begin
        if (reset) begin
            scale_cnt <= SCALE_TOP;
            scale_reg <= 3'd2;
        end else begin
            if ((state == COMMIT) && loc_full) begin
                scale_cnt <= SCALE_TOP;
            end else if (state == SCALE) begin
                if (scale_done) begin
                    scale_reg <= scale_cnt;
                end else begin
                    scale_cnt <= scale_cnt - 3'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_display_update_sequencer.sv
// Scoreboard bench for display_update_sequencer: expected commits queued at ack, checked at new_data.
module tb_display_update_sequencer;

    localparam int SMAX  = 4;
    localparam int GRID  = 256;
    localparam int STALE = 60;

    logic        vclock = 1'b0;
    logic        reset;
    logic        vsync;
    logic        loc_valid;
    logic [11:0] loc_data;
    logic        loc_ack;
    logic        ori_valid;
    logic [4:0]  ori_data;
    logic        ori_ack;
    logic [11:0] location;
    logic [4:0]  orientation;
    logic        new_data;
    logic        orientation_ready;
    logic [2:0]  scale_factor;
    logic        stale;

    display_update_sequencer #(
        .SCALE_MAX    (SMAX),
        .GRID_LIMIT   (GRID),
        .STALE_FRAMES (STALE)
    ) dut (
        .vclock            (vclock),
        .reset             (reset),
        .vsync             (vsync),
        .loc_valid         (loc_valid),
        .loc_data          (loc_data),
        .loc_ack           (loc_ack),
        .ori_valid         (ori_valid),
        .ori_data          (ori_data),
        .ori_ack           (ori_ack),
        .location          (location),
        .orientation       (orientation),
        .new_data          (new_data),
        .orientation_ready (orientation_ready),
        .scale_factor      (scale_factor),
        .stale             (stale)
    );

    always #5 vclock = ~vclock;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_q[$];
    int          nd_count = 0;
    int          sc_wait = 0;
    logic [2:0]  sc_exp = 3'd0;
    logic        nd_prev = 1'b0;
    logic [11:0] mon_e;
    logic        nd_at2;
    logic        ordy_at2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] exp_scale(input logic [7:0] r);
`ifdef SEQ_AUTOSCALE_EN
        for (int s = SMAX; s >= 1; s--) begin
            if (int'(r) * s <= GRID) return 3'(s);
        end
        return 3'd1;
`else
        return 3'd2;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge vclock);
        #1;
    endtask

    // Commit monitor: location against the scoreboard, scale a fixed 4 cycles later.
    always @(negedge vclock) begin
        if (reset) begin
            sc_wait = 0;
            nd_prev = 1'b0;
        end else begin
            if (new_data) begin
                nd_count++;
                if (nd_prev) check("new_data_single_cycle", 1, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_commit", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("commit_location", location, mon_e);
                    sc_exp  = exp_scale(mon_e[11:4]);
                    sc_wait = 4;
                end
            end else if (sc_wait > 0) begin
                sc_wait--;
                if (sc_wait == 0) check("scale_factor", scale_factor, sc_exp);
            end
            nd_prev = new_data;
        end
    end

    task automatic check_reset_outputs();
        check("rst_location", location, 0);
        check("rst_orientation", orientation, 0);
        check("rst_new_data", new_data, 0);
        check("rst_orientation_ready", orientation_ready, 0);
        check("rst_scale_factor", scale_factor, 2);
        check("rst_stale", stale, 0);
        check("rst_loc_ack", loc_ack, 0);
        check("rst_ori_ack", ori_ack, 0);
    endtask

    task automatic send_loc(input logic [11:0] d, output int lat);
        lat = 0;
        loc_valid = 1'b1;
        loc_data  = d;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (loc_ack) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            check("loc_ack_timeout", 0, 1);
        end else begin
            exp_q.push_back(d);
            tick(1);
            check("loc_ack_one_cycle", loc_ack, 0);
        end
        loc_valid = 1'b0;
    endtask

    task automatic frame();
        vsync = 1'b0;
        tick(2);
        nd_at2   = new_data;
        ordy_at2 = orientation_ready;
        tick(8);
        vsync = 1'b1;
        tick(2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          n0;
        int          nd_ack;
        logic        early;
        logic [7:0]  radii[3];

        reset = 1'b1; vsync = 1'b1; loc_valid = 1'b0; ori_valid = 1'b0;
        loc_data = '0; ori_data = '0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check_reset_outputs();

        send_loc(12'h405, lat);
        check("loc_ack_latency", lat, 1);
        n0 = nd_count;
        frame();
        check("new_data_at_frame", nd_at2, 1);
        check("new_data_once", nd_count - n0, 1);
        check("location_405", location, 12'h405);

        radii[0] = 8'd200; radii[1] = 8'd100; radii[2] = 8'd0;
        for (int i = 0; i < 3; i++) begin
            send_loc({radii[i], 4'h1}, lat);
            n0 = nd_count;
            frame();
            check("radius_commit", nd_count - n0, 1);
        end

        check("ori_ready_before", orientation_ready, 0);
        loc_valid = 1'b1; loc_data = 12'hC83;
        ori_valid = 1'b1; ori_data = 5'h15;
        tick(1);
        check("both_loc_ack", loc_ack, 1);
        check("both_ori_ack", ori_ack, 1);
        exp_q.push_back(12'hC83);
        tick(1);
        loc_valid = 1'b0; ori_valid = 1'b0;
        frame();
        check("both_new_data", nd_at2, 1);
        check("both_ori_ready", ordy_at2, 1);
        check("both_orientation", orientation, 5'h15);

        send_loc(12'h321, lat);
        loc_valid = 1'b1; loc_data = 12'h654;
        early = 1'b0;
        repeat (5) begin
            tick(1);
            if (loc_ack) early = 1'b1;
        end
        check("no_ack_while_full", early, 0);
        n0 = nd_count;
        nd_ack = -1;
        vsync = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (loc_ack) begin
                nd_ack = nd_count;
                break;
            end
        end
        check("second_ack_after_commit", nd_ack - n0, 1);
        if (nd_ack >= 0) exp_q.push_back(12'h654);
        tick(1);
        loc_valid = 1'b0;
        tick(5);
        vsync = 1'b1;
        tick(2);
        frame();
        check("second_commits_next_frame", nd_count - n0, 2);
        check("location_654", location, 12'h654);

        repeat (STALE - 1) frame();
        check("stale_before_limit", stale, 0);
        check("ori_ready_before_limit", orientation_ready, 1);
        frame();
        check("stale_at_limit", stale, 1);
        check("ori_ready_cleared", orientation_ready, 0);
        send_loc(12'h0A2, lat);
        frame();
        check("stale_cleared", stale, 0);

        send_loc(12'h7F3, lat);
        vsync = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        check("rst_commit_new_data", new_data, 0);
        check("rst_commit_location", location, 0);
        exp_q.delete();
        reset = 1'b0;
        vsync = 1'b1;
        tick(2);
        n0 = nd_count;
        frame();
        check("slot_discarded", nd_count - n0, 0);

        send_loc({8'd200, 4'h0}, lat);
        vsync = 1'b0;
        tick(2);
        check("scale_rst_new_data", new_data, 1);
        tick(1);
        reset = 1'b1;
        tick(1);
        check_reset_outputs();
        reset = 1'b0;
        vsync = 1'b1;
        tick(2);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
